// File: rtl/countdown_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : countdown_ctrl
// Purpose  : IDLE/RUN/PAUSE/DONE sequencer for the 60 s countdown: 1 s
//            prescaler, two-digit BCD down-counter, preset and LED bank.
//            Define COUNTDOWN_ALARM_BLINK_EN for a blinking alarm in DONE.
// Revision : 1.0 - initial release
// ============================================================================
module countdown_ctrl #(
    parameter int         CLK_HZ         = 12_000_000,
    parameter logic [7:0] PRESET_DEFAULT = 8'h59
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        key_start,
    input  logic        key_clr,
    input  logic        key_inc,
    output logic [3:0]  bcd_tens,
    output logic [3:0]  bcd_ones,
    output logic [1:0]  state,
    output logic        tick_1s,
    output logic        done,
    output logic [13:0] led
);

    localparam int            PW    = $clog2(CLK_HZ);
    localparam logic [PW-1:0] C_TC  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] C_ONE = PW'(1);
`ifdef COUNTDOWN_ALARM_BLINK_EN
    localparam logic [PW-1:0] C_HALF = PW'(CLK_HZ / 2);
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    preset_q, preset_d;
    logic [7:0]    count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          done_q, done_d;
    logic [13:0]   led_q, led_d;
    logic          at_tc;

    // Preset increment: 09 -> 10, 59 wraps to 01 so 00 is never a preset.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h59)
            r = 8'h01;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0)
            r = {v[7:4] - 4'd1, 4'd9};
        else
            r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        preset_d = preset_q;
        count_d  = count_q;
        presc_d  = presc_q;
        tick_d   = 1'b0;
        at_tc    = (presc_q == C_TC);

        case (state_q)
            ST_IDLE: begin
                if (key_start) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                end else if (key_inc) begin
                    preset_d = bcd_inc(preset_q);
                end
                count_d = preset_d;
            end
            ST_RUN: begin
                // The key_start cycle itself is the first paused cycle.
                if (at_tc) begin
                    presc_d = '0;
                    count_d = bcd_dec(count_q);
                    tick_d  = 1'b1;
                end else if (!key_start) begin
                    presc_d = presc_q + C_ONE;
                end
                if (at_tc && (count_q == 8'h01))
                    state_d = ST_DONE;
                else if (key_start)
                    state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (key_start)
                    state_d = ST_RUN;
            end
            ST_DONE: begin
                count_d = 8'h00;
`ifdef COUNTDOWN_ALARM_BLINK_EN
                presc_d = at_tc ? '0 : presc_q + C_ONE;
`else
                presc_d = '0;
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        if (key_clr) begin
            state_d  = ST_IDLE;
            presc_d  = '0;
            preset_d = preset_q;
            count_d  = preset_q;
            tick_d   = 1'b0;
        end

        done_d = (state_d == ST_DONE);
        case (state_d)
            ST_RUN:   led_d = 14'h1FFF;
            ST_PAUSE: led_d = 14'h2FFF;
`ifdef COUNTDOWN_ALARM_BLINK_EN
            ST_DONE:  led_d = (presc_d < C_HALF) ? 14'h0000 : 14'h3FFF;
`else
            ST_DONE:  led_d = 14'h0000;
`endif
            default:  led_d = 14'h3FFF;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= ST_IDLE;
            preset_q <= PRESET_DEFAULT;
            count_q  <= PRESET_DEFAULT;
            presc_q  <= '0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
            led_q    <= 14'h3FFF;
        end else begin
            state_q  <= state_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
            led_q    <= led_d;
        end
    end

    assign state    = state_q;
    assign bcd_tens = count_q[7:4];
    assign bcd_ones = count_q[3:0];
    assign tick_1s  = tick_q;
    assign done     = done_q;
    assign led      = led_q;

endmodule
`default_nettype wire

// File: tb/tb_countdown_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_ctrl
// Purpose  : Directed self-checking bench for countdown_ctrl at CLK_HZ=20.
// Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_ctrl;

    localparam int C_HZ = 20;
`ifdef COUNTDOWN_ALARM_BLINK_EN
    localparam logic [13:0] C_LED_BLINK2 = 14'h3FFF;
`else
    localparam logic [13:0] C_LED_BLINK2 = 14'h0000;
`endif

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        key_start = 1'b0;
    logic        key_clr = 1'b0;
    logic        key_inc = 1'b0;
    logic [3:0]  bcd_tens;
    logic [3:0]  bcd_ones;
    logic [1:0]  state;
    logic        tick_1s;
    logic        done;
    logic [13:0] led;

    int total = 0;
    int bad = 0;

    countdown_ctrl #(
        .CLK_HZ         (C_HZ),
        .PRESET_DEFAULT (8'h59)
    ) dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .key_start (key_start),
        .key_clr   (key_clr),
        .key_inc   (key_inc),
        .bcd_tens  (bcd_tens),
        .bcd_ones  (bcd_ones),
        .state     (state),
        .tick_1s   (tick_1s),
        .done      (done),
        .led       (led)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic key(input logic s, input logic c, input logic i);
        key_start = s;
        key_clr   = c;
        key_inc   = i;
        cyc(1);
        key_start = 1'b0;
        key_clr   = 1'b0;
        key_inc   = 1'b0;
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    initial begin
        int  n;
        int  guard;
        bit  bcd_ok;

        // Reset state
        cyc(2);
        chk("rst_state", state, 2'b00);
        chk("rst_count", {bcd_tens, bcd_ones}, 8'h59);
        chk("rst_led", led, 14'h3FFF);
        chk("rst_tick", tick_1s, 1'b0);
        chk("rst_done", done, 1'b0);
        rst_n_in = 1'b1;
        cyc(1);

        // Full countdown 59 -> 00 with per-second checks
        key(1'b1, 1'b0, 1'b0);
        chk("start_state", state, 2'b01);
        chk("start_led", led, 14'h1FFF);
        chk("start_count", {bcd_tens, bcd_ones}, 8'h59);
        n = 59;
        bcd_ok = 1'b1;
        for (int k = 1; k <= 59 * C_HZ; k++) begin
            cyc(1);
            if (bcd_tens > 4'd5 || bcd_ones > 4'd9)
                bcd_ok = 1'b0;
            if (k % C_HZ == 0) begin
                n = n - 1;
                chk("tick_hi", tick_1s, 1'b1);
                chk("tick_cnt", {bcd_tens, bcd_ones}, to_bcd(n));
            end else if (k % C_HZ == 1 && k > 1) begin
                chk("tick_width", tick_1s, 1'b0);
            end else if (k % C_HZ == C_HZ - 1) begin
                chk("pre_tick", tick_1s, 1'b0);
                chk("pre_tick_cnt", {bcd_tens, bcd_ones}, to_bcd(n));
            end
        end
        chk("bcd_valid", bcd_ok, 1'b1);
        chk("done_state", state, 2'b11);
        chk("done_flag", done, 1'b1);
        chk("done_led0", led, 14'h0000);
        cyc(9);
        chk("done_led_9", led, 14'h0000);
        chk("done_tick0", tick_1s, 1'b0);
        cyc(1);
        chk("done_led_10", led, C_LED_BLINK2);
        key(1'b1, 1'b0, 1'b0);
        chk("done_ign_start", state, 2'b11);
        chk("done_ign_cnt", {bcd_tens, bcd_ones}, 8'h00);
        key(1'b0, 1'b0, 1'b1);
        chk("done_ign_inc", state, 2'b11);

        // Clear from DONE
        key(1'b0, 1'b1, 1'b0);
        chk("clr_state", state, 2'b00);
        chk("clr_count", {bcd_tens, bcd_ones}, 8'h59);
        chk("clr_led", led, 14'h3FFF);
        chk("clr_done", done, 1'b0);

        // Preset increments: 59 -> 01 -> ... -> 57, then 58, 59, 01
        for (int i = 1; i <= 57; i++) begin
            key(1'b0, 1'b0, 1'b1);
            if (i == 1)  chk("inc_wrap", {bcd_tens, bcd_ones}, 8'h01);
            if (i == 9)  chk("inc_09", {bcd_tens, bcd_ones}, 8'h09);
            if (i == 10) chk("inc_10", {bcd_tens, bcd_ones}, 8'h10);
        end
        chk("inc_57", {bcd_tens, bcd_ones}, 8'h57);
        key(1'b0, 1'b0, 1'b1);
        chk("inc_58", {bcd_tens, bcd_ones}, 8'h58);
        key(1'b0, 1'b0, 1'b1);
        chk("inc_59", {bcd_tens, bcd_ones}, 8'h59);
        key(1'b0, 1'b0, 1'b1);
        chk("inc_01", {bcd_tens, bcd_ones}, 8'h01);
        key(1'b1, 1'b0, 1'b1);
        chk("start_over_inc", {bcd_tens, bcd_ones}, 8'h01);
        cyc(C_HZ - 1);
        chk("p01_pre", {bcd_tens, bcd_ones}, 8'h01);
        cyc(1);
        chk("p01_count", {bcd_tens, bcd_ones}, 8'h00);
        chk("p01_state", state, 2'b11);
        chk("p01_done", done, 1'b1);
        chk("p01_led", led, 14'h0000);
        cyc(C_HZ / 2);
        chk("p01_blink", led, C_LED_BLINK2);
        key(1'b0, 1'b1, 1'b0);
        chk("clr_keeps_preset", {bcd_tens, bcd_ones}, 8'h01);

        // Reset restores default preset
        rst_n_in = 1'b0;
        cyc(2);
        rst_n_in = 1'b1;
        cyc(1);
        chk("rst2_count", {bcd_tens, bcd_ones}, 8'h59);

        // Pause at prescaler 7 for 100 cycles, resume
        key(1'b1, 1'b0, 1'b0);
        cyc(7);
        key(1'b1, 1'b0, 1'b0);
        chk("pause_state", state, 2'b10);
        chk("pause_led", led, 14'h2FFF);
        cyc(100);
        chk("pause_hold_cnt", {bcd_tens, bcd_ones}, 8'h59);
        chk("pause_hold_state", state, 2'b10);
        chk("pause_tick", tick_1s, 1'b0);
        key(1'b1, 1'b0, 1'b0);
        chk("resume_state", state, 2'b01);
        cyc(12);
        chk("resume_pre_tick", tick_1s, 1'b0);
        chk("resume_pre_cnt", {bcd_tens, bcd_ones}, 8'h59);
        cyc(1);
        chk("resume_tick", tick_1s, 1'b1);
        chk("resume_cnt", {bcd_tens, bcd_ones}, 8'h58);

        // key_start coinciding with a tick: decrement then PAUSE
        cyc(C_HZ - 1);
        key(1'b1, 1'b0, 1'b0);
        chk("tickpause_cnt", {bcd_tens, bcd_ones}, 8'h57);
        chk("tickpause_tick", tick_1s, 1'b1);
        chk("tickpause_state", state, 2'b10);
        key(1'b1, 1'b0, 1'b0);
        chk("tickpause_resume", state, 2'b01);

        // key_clr + key_start together at count 31
        guard = 0;
        while ({bcd_tens, bcd_ones} != 8'h31 && guard < 2000) begin
            cyc(1);
            guard++;
        end
        chk("wait31_timeout", guard < 2000, 1'b1);
        key(1'b1, 1'b1, 1'b0);
        chk("clrstart_state", state, 2'b00);
        chk("clrstart_cnt", {bcd_tens, bcd_ones}, 8'h59);
        chk("clrstart_led", led, 14'h3FFF);

        // Asynchronous reset mid-RUN at count 42
        key(1'b1, 1'b0, 1'b0);
        guard = 0;
        while ({bcd_tens, bcd_ones} != 8'h42 && guard < 2000) begin
            cyc(1);
            guard++;
        end
        chk("wait42_timeout", guard < 2000, 1'b1);
        chk("at42_tick", tick_1s, 1'b1);
        #3;
        rst_n_in = 1'b0;
        #1;
        chk("arst_cnt", {bcd_tens, bcd_ones}, 8'h59);
        chk("arst_state", state, 2'b00);
        chk("arst_led", led, 14'h3FFF);
        chk("arst_tick", tick_1s, 1'b0);
        #2;
        rst_n_in = 1'b1;
        cyc(1);
        chk("post_arst_state", state, 2'b00);
        key(1'b1, 1'b0, 1'b0);
        chk("post_arst_run", state, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
